uart_resp_tx: RTL and testbench



---
 rtl/uart_resp_tx_if.sv | 22 ++
 rtl/uart_resp_tx.sv | 111 +++++++++++
 tb/tb_uart_resp_tx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_resp_tx_if.sv
// Response-transmitter handshake bundle: send strobe, response word,
// flag clear, and the serial line with its status flags.
interface uart_resp_tx_if #(
   parameter int NUM_BYTES = 3
);
   logic                   snd;
   logic [8*NUM_BYTES-1:0] resp;
   logic                   clr_resp_sent;
   logic                   TX;
   logic                   busy;
   logic                   resp_sent;

   modport master (
      output snd, resp, clr_resp_sent,
      input  TX, busy, resp_sent
   );

   modport slave (
      input  snd, resp, clr_resp_sent,
      output TX, busy, resp_sent
   );
endinterface

// File: rtl/uart_resp_tx.sv
// Serialises a latched response word as back-to-back 8N1 frames, high byte
// first, with no idle gap between frames and a sticky completion flag.
module uart_resp_tx #(
   parameter int BAUD_DIV  = 2604,
   parameter int NUM_BYTES = 3
) (
   input  logic           clk,
   input  logic           rst,
   uart_resp_tx_if.slave  bus
);
   localparam int W     = 8 * NUM_BYTES;
   localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
   localparam logic [15:0]      BAUD_RELOAD = 16'(BAUD_DIV - 1);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_BYTES - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state;
   logic [15:0]      baud_cnt;
   logic [3:0]       bit_cnt;
   logic [IDX_W-1:0] byte_idx;
   logic [W-1:0]     hold;
   logic [9:0]       frame;
   logic [9:0]       frame_next;
   logic             accept;
   logic             bit_end;
   logic             load_next;

   always_comb begin
      accept     = bus.snd && (state == IDLE);
      bit_end    = (state != IDLE) && (baud_cnt == 16'd0);
      load_next  = bit_end && (state == STOP) && (byte_idx != LAST_IDX);
      frame_next = frame;
      if (accept)
         frame_next = {1'b1, bus.resp[W-1 -: 8], 1'b0};
      else if (load_next)
         frame_next = {1'b1, hold[W-9 -: 8], 1'b0};
      else if (bit_end)
         frame_next = {1'b1, frame[9:1]};
   end

   // Holding register rotates a byte per frame so the next byte is always
   // just below the top; it needs no reset because accept reloads it.
   always_ff @(posedge clk) begin
      frame <= frame_next;
      if (accept)
         hold <= bus.resp;
      else if (load_next)
         hold <= {hold[W-9:0], hold[W-1 -: 8]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         baud_cnt      <= '0;
         bit_cnt       <= '0;
         byte_idx      <= '0;
         bus.TX        <= 1'b1;
         bus.busy      <= 1'b0;
         bus.resp_sent <= 1'b0;
      end else begin
         if (bus.clr_resp_sent)
            bus.resp_sent <= 1'b0;
         // TX always takes the low bit of the frame being presented next.
         if (accept || bit_end)
            bus.TX <= frame_next[0];
         if (state != IDLE)
            baud_cnt <= bit_end ? BAUD_RELOAD : baud_cnt - 16'd1;

         case (state)
            IDLE: begin
               if (bus.snd) begin
                  state         <= START;
                  baud_cnt      <= BAUD_RELOAD;
                  bit_cnt       <= '0;
                  byte_idx      <= '0;
                  bus.busy      <= 1'b1;
                  bus.resp_sent <= 1'b0;
               end
            end
            START: begin
               if (bit_end) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (bit_end) begin
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7)
                     state <= STOP;
               end
            end
            STOP: begin
               if (bit_end) begin
                  if (byte_idx == LAST_IDX) begin
                     state         <= IDLE;
                     bus.TX        <= 1'b1;
                     bus.busy      <= 1'b0;
                     bus.resp_sent <= 1'b1;
                  end else begin
                     state    <= START;
                     byte_idx <= byte_idx + IDX_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_resp_tx.sv
// Bench for uart_resp_tx: two instances (16 and 4 clocks per bit) checked
// cycle by cycle against a line model built from the 8N1 frame rules.
module tb_uart_resp_tx;
   logic        clk = 1'b0;
   logic        rst;
   logic        snd16, snd4, clr;
   logic [23:0] resp;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   uart_resp_tx_if bus16 ();
   uart_resp_tx_if bus4 ();

   assign bus16.snd           = snd16;
   assign bus16.resp          = resp;
   assign bus16.clr_resp_sent = clr;
   assign bus4.snd            = snd4;
   assign bus4.resp           = resp;
   assign bus4.clr_resp_sent  = clr;

   uart_resp_tx #(.BAUD_DIV(16), .NUM_BYTES(3)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
   uart_resp_tx #(.BAUD_DIV(4),  .NUM_BYTES(3)) dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));

   typedef struct {
      logic [23:0] resp;
      int          sel;
      int          clr_mode;
      logic        exp_sent;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic tx_of(input int sel);
      return (sel != 0) ? bus4.TX : bus16.TX;
   endfunction

   function automatic logic busy_of(input int sel);
      return (sel != 0) ? bus4.busy : bus16.busy;
   endfunction

   function automatic logic sent_of(input int sel);
      return (sel != 0) ? bus4.resp_sent : bus16.resp_sent;
   endfunction

   function automatic int div_of(input int sel);
      return (sel != 0) ? 4 : 16;
   endfunction

   task automatic set_snd(input int sel, input logic v);
      if (sel != 0) snd4 = v;
      else          snd16 = v;
   endtask

   // Line level for bit slot i (0..29) of a word: per frame start 0, eight
   // data bits LSB first, stop 1; frames in order high byte to low byte.
   function automatic logic line_bit(input logic [23:0] w, input int i);
      int         f = i / 10;
      int         p = i % 10;
      logic [7:0] b;
      b = 8'(w >> (8 * (2 - f)));
      if (p == 0) return 1'b0;
      if (p == 9) return 1'b1;
      return b[p-1];
   endfunction

   task automatic start_word(input int sel, input logic [23:0] w);
      set_snd(sel, 1'b1);
      resp = w;
      tick();
      set_snd(sel, 1'b0);
   endtask

   // Entered one cycle after the accepting edge; leaves after completion
   // (or at the first cycle of the chained word when chain is set).
   task automatic run_word(input int sel, input logic [23:0] w, input int clr_mode,
                           input int inject_at, input bit chain, input logic [23:0] next_w,
                           input logic exp_sent);
      int          div = div_of(sel);
      int          n   = 30 * div;
      logic [29:0] mid = '0;
      logic [23:0] dec = '0;
      for (int c = 0; c < n; c++) begin
         chk($sformatf("tx d%0d c%0d", div, c), 32'(tx_of(sel)), 32'(line_bit(w, c / div)));
         chk($sformatf("busy d%0d c%0d", div, c), 32'(busy_of(sel)), 32'd1);
         if (c == 0) chk("sent_cleared_on_accept", 32'(sent_of(sel)), 32'd0);
         if (c % div == div / 2) mid[c / div] = tx_of(sel);
         if (inject_at >= 0 && c == inject_at) begin
            set_snd(sel, 1'b1);
            resp = 24'h123456;
         end
         if (inject_at >= 0 && c == inject_at + 1) set_snd(sel, 1'b0);
         if (c == n - 1 && clr_mode == 1) clr = 1'b1;
         if (c == n - 1 && chain) begin
            set_snd(sel, 1'b1);
            resp = next_w;
         end
         tick();
      end
      clr = 1'b0;
      chk("busy_after_word", 32'(busy_of(sel)), 32'd0);
      chk("tx_after_word", 32'(tx_of(sel)), 32'd1);
      for (int f = 0; f < 3; f++) begin
         chk($sformatf("framing f%0d", f), 32'({mid[f*10], mid[f*10+9]}), 32'b01);
         dec = {dec[15:0], mid[f*10+1 +: 8]};
      end
      chk("decoded_word", 32'(dec), 32'(w));
      if (clr_mode == 2) begin
         clr = 1'b1;
         tick();
         clr = 1'b0;
      end
      chk("resp_sent", 32'(sent_of(sel)), 32'(exp_sent));
      if (chain) begin
         tick();
         set_snd(sel, 1'b0);
      end
   endtask

   initial begin
      vecs[0] = '{resp: 24'hA53C0F, sel: 0, clr_mode: 0, exp_sent: 1'b1};
      vecs[1] = '{resp: 24'hA53C0F, sel: 0, clr_mode: 1, exp_sent: 1'b1};
      vecs[2] = '{resp: 24'h5A00FF, sel: 0, clr_mode: 2, exp_sent: 1'b0};
      vecs[3] = '{resp: 24'hFFFFFF, sel: 1, clr_mode: 0, exp_sent: 1'b1};
      vecs[4] = '{resp: 24'h000000, sel: 1, clr_mode: 2, exp_sent: 1'b0};
      vecs[5] = '{resp: 24'h800001, sel: 1, clr_mode: 1, exp_sent: 1'b1};

      rst = 1'b1; snd16 = 1'b0; snd4 = 1'b0; clr = 1'b0; resp = '0;
      tick();
      tick();
      for (int s = 0; s < 2; s++) begin
         chk($sformatf("reset_tx s%0d", s), 32'(tx_of(s)), 32'd1);
         chk($sformatf("reset_busy s%0d", s), 32'(busy_of(s)), 32'd0);
         chk($sformatf("reset_sent s%0d", s), 32'(sent_of(s)), 32'd0);
      end
      rst = 1'b0;
      tick();

      for (int k = 0; k < 6; k++) begin
         start_word(vecs[k].sel, vecs[k].resp);
         run_word(vecs[k].sel, vecs[k].resp, vecs[k].clr_mode, -1, 1'b0, 24'h0, vecs[k].exp_sent);
         tick();
      end

      // snd mid-word is ignored; snd on the busy-falling cycle lands one cycle later
      start_word(0, 24'hA53C0F);
      run_word(0, 24'hA53C0F, 0, 100, 1'b1, 24'h123456, 1'b1);
      run_word(0, 24'h123456, 0, -1, 1'b0, 24'h0, 1'b1);
      tick();

      // asynchronous reset in the middle of a frame
      start_word(0, 24'hA53C0F);
      repeat (199) tick();
      #2 rst = 1'b1;
      #1;
      chk("async_rst_tx", 32'(bus16.TX), 32'd1);
      chk("async_rst_busy", 32'(bus16.busy), 32'd0);
      chk("async_rst_sent", 32'(bus16.resp_sent), 32'd0);
      tick();
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         chk($sformatf("post_rst_tx c%0d", c), 32'(bus16.TX), 32'd1);
         chk($sformatf("post_rst_busy c%0d", c), 32'(bus16.busy), 32'd0);
      end
      start_word(0, 24'h000000);
      run_word(0, 24'h000000, 0, -1, 1'b0, 24'h0, 1'b1);

      for (int k = 0; k < 8; k++) begin
         int          sel  = int'($urandom_range(0, 1));
         int          mode = int'($urandom_range(0, 2));
         logic [23:0] w    = 24'($urandom);
         repeat ($urandom_range(0, 3)) tick();
         start_word(sel, w);
         run_word(sel, w, mode, -1, 1'b0, 24'h0, (mode != 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
